trivium_ks_ctrl: RTL and testbench
==================================

Name: trivium_ks_ctrl

Overview:
- Job sequencer for the Trivium keystream core. Accepts a job (key, IV, byte length) over a start handshake.
- Loads the core, runs the warm-up rounds, then steps the core one round per cycle.
- Packs keystream bits into bytes and delivers them over a valid/ready stream; pulses done at job end.
- Sits between the host/DMA job interface and one Trivium core instance.

Parameters:
- WARMUP, 1152, number of blank rounds after load (4 x 288).
- LEN_W, 12, width of the job length field in bytes (max 4095).
- CNT_W, 11, width of the warm-up counter; must hold WARMUP.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  job request.
- start_ready  out  1  high only in IDLE.
- key  in  80  job key, sampled on accept.
- iv  in  80  job IV, sampled on accept.
- len  in  LEN_W  job length in bytes, sampled on accept.
- abort  in  1  cancel the current job.
- core_load  out  1  core loads state from core_key/core_iv at this edge.
- core_key  out  80  latched key.
- core_iv  out  80  latched IV.
- core_step  out  1  core advances one round at this edge.
- core_ks  in  1  core output bit for its current state (combinational in the core).
- ks_data  out  8  keystream byte.
- ks_valid  out  1  ks_data valid.
- ks_ready  in  1  downstream accepts the byte.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: state goes to IDLE. All outputs are 0 except start_ready=1. core_key, core_iv and ks_data are cleared to 0.
- Core contract: core_load and core_step are never high together. Both are registered outputs.
- IDLE: a job is accepted when start && start_ready. On accept, latch key, iv and len.
  - len==0: go to DONE. The core is not touched.
  - len!=0: go to LOAD.
- LOAD: core_load=1 for exactly one cycle, then go to WARM with the warm counter cleared.
- WARM: core_step=1 every cycle for exactly WARMUP cycles. After the last one, go to GEN with bit_cnt=0.
- GEN: core_step=1. Each cycle, core_ks is captured into ks_data[bit_cnt] before the step takes effect.
  - The first keystream bit goes to the byte LSB.
  - After 8 cycles, go to HOLD.
- HOLD: ks_valid=1, core_step=0, and ks_data is held stable.
  - On ks_ready, decrement bytes_left.
  - If bytes_left becomes 0, go to DONE; otherwise go to GEN.
  - Throughput is 9 cycles per byte when ks_ready is held high.
- DONE: done=1 for one cycle, then go to IDLE.
- Latency: if the accepting edge is E0, ks_valid first rises after edge E0+WARMUP+9 (edge 1161 for the default WARMUP).
- abort: sampled in any non-IDLE state. The next edge goes to IDLE with ks_valid=0 and no done pulse. A partially built byte is discarded. abort in IDLE is ignored.
- abort together with start in IDLE: the start is accepted.
- start while busy is ignored; start_ready=0 until IDLE.
- Asynchronous reset mid-job has the same effect as a power-on reset. The next job reloads the core.
- bytes_left is LEN_W wide. len=4095 must complete without wrap.

Optional Feature:
- Macro: TRIV_XOR_EN.
- Defined: adds ports din (8-bit in), din_valid (in) and din_ready (out).
  - In HOLD, ks_data = keystream byte ^ din.
  - ks_valid = din_valid.
  - din_ready = ks_ready, and only in HOLD.
  - A byte is consumed only when din_valid && ks_ready.
  - The block becomes a byte-stream encryptor/decryptor.
- Undefined: these ports are absent and ks_data is the raw keystream.

Test Plan:
- Key=0, IV=0, len=4, ks_ready held 1: core_load pulses once; exactly 1152 core_step cycles before the first GEN. The 4 bytes equal a bit-accurate Trivium model output, LSB-first. done pulses once after the 4th handshake. The total count of core_step cycles is 1152+32.
- len=0 with start: no core_load and no core_step; done one cycle after accept; start_ready back next cycle.
- len=2, ks_ready low for 20 cycles in the first HOLD: ks_valid and ks_data stay stable and core_step stays 0. Bytes still match the model.
- abort asserted at warm-up cycle 500, then a new job with key=0xFFFF...: no done and no ks_valid from the first job. The second job's bytes match the model.
- reset pulsed mid-GEN: all outputs are 0 immediately (asynchronous) and start_ready=1. The next job is correct.
- TRIV_XOR_EN with din=0x00 then 0xA5: outputs equal ks and ks^0xA5. din_valid low stalls the output even with ks_ready=1.

Source files
------------

// File: rtl/trivium_ks_ctrl_if.sv
// Job, core and keystream-stream signals of the Trivium keystream sequencer.
// Signal suffixes are written from the sequencer's point of view (_i = into it).
// With TRIV_XOR_EN defined, the din/din_valid/din_ready data-in stream is added.
interface trivium_ks_ctrl_if #(
  parameter int LEN_W = 12
);
  // host / DMA job side
  logic             start_i;
  logic             start_ready_o;
  logic [79:0]      key_i;
  logic [79:0]      iv_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  // Trivium core side
  logic             core_load_o;
  logic [79:0]      core_key_o;
  logic [79:0]      core_iv_o;
  logic             core_step_o;
  logic             core_ks_i;
  // keystream byte stream
  logic [7:0]       ks_data_o;
  logic             ks_valid_o;
  logic             ks_ready_i;
  logic             done_o;
`ifdef TRIV_XOR_EN
  logic [7:0]       din_i;
  logic             din_valid_i;
  logic             din_ready_o;

  modport slave (
    input  start_i, key_i, iv_i, len_i, abort_i, core_ks_i, ks_ready_i, din_i, din_valid_i,
    output start_ready_o, core_load_o, core_key_o, core_iv_o, core_step_o,
           ks_data_o, ks_valid_o, done_o, din_ready_o
  );
  modport master (
    output start_i, key_i, iv_i, len_i, abort_i, core_ks_i, ks_ready_i, din_i, din_valid_i,
    input  start_ready_o, core_load_o, core_key_o, core_iv_o, core_step_o,
           ks_data_o, ks_valid_o, done_o, din_ready_o
  );
`else
  modport slave (
    input  start_i, key_i, iv_i, len_i, abort_i, core_ks_i, ks_ready_i,
    output start_ready_o, core_load_o, core_key_o, core_iv_o, core_step_o,
           ks_data_o, ks_valid_o, done_o
  );
  modport master (
    output start_i, key_i, iv_i, len_i, abort_i, core_ks_i, ks_ready_i,
    input  start_ready_o, core_load_o, core_key_o, core_iv_o, core_step_o,
           ks_data_o, ks_valid_o, done_o
  );
`endif
endinterface

// File: rtl/trivium_ks_ctrl.sv
// Trivium keystream job sequencer: accepts a (key, IV, length) job, loads the
// core, runs the warm-up rounds, then packs one keystream bit per cycle into
// LSB-first bytes delivered on a valid/ready stream, pulsing done at the end.
// Optional macro TRIV_XOR_EN: XOR each byte with an input data stream (din),
// turning the block into a byte-stream encryptor/decryptor.
module trivium_ks_ctrl #(
  parameter int WARMUP = 1152,
  parameter int LEN_W  = 12,
  parameter int CNT_W  = 11
) (
  input logic              clk,
  input logic              rst,
  trivium_ks_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WARM = 3'd2,
    ST_GEN  = 3'd3,
    ST_HOLD = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] warm_cnt_q,   warm_cnt_d;
  logic [2:0]       bit_cnt_q,    bit_cnt_d;
  logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
  logic [79:0]      key_q,        key_d;
  logic [79:0]      iv_q,         iv_d;
  logic [7:0]       ks_byte_q,    ks_byte_d;
  logic             start_ready_q;
  logic             core_load_q;
  logic             core_step_q;
  logic             ks_valid_q;
  logic             done_q;
  logic             hold_fire_s;

  // A byte leaves HOLD only when the downstream (and, with XOR, the data source) is ready.
`ifdef TRIV_XOR_EN
  assign hold_fire_s = bus.ks_ready_i & bus.din_valid_i;
`else
  assign hold_fire_s = bus.ks_ready_i;
`endif

  // Next-state and datapath update; abort overrides everything outside IDLE.
  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_left_d = bytes_left_q;
    key_d        = key_q;
    iv_d         = iv_q;
    ks_byte_d    = ks_byte_q;
    if ((state_q != ST_IDLE) && bus.abort_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      ks_byte_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            key_d        = bus.key_i;
            iv_d         = bus.iv_i;
            bytes_left_d = bus.len_i;
            if (bus.len_i == {LEN_W{1'b0}}) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          warm_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_WARM;
        end
        ST_WARM: begin
          if (warm_cnt_q == WARM_LAST) begin
            bit_cnt_d = 3'd0;
            state_d   = ST_GEN;
          end else begin
            warm_cnt_d = warm_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_GEN: begin
          // core_ks reflects the pre-step state, so it is captured on the stepping edge
          ks_byte_d[bit_cnt_q] = bus.core_ks_i;
          bit_cnt_d            = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_GEN;
          end
        end
        ST_HOLD: begin
          if (hold_fire_s) begin
            bytes_left_d = bytes_left_q - LEN_W'(1);
            bit_cnt_d    = 3'd0;
            if (bytes_left_q == LEN_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_GEN;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; outputs are decoded from the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      warm_cnt_q    <= {CNT_W{1'b0}};
      bit_cnt_q     <= 3'd0;
      bytes_left_q  <= {LEN_W{1'b0}};
      key_q         <= 80'd0;
      iv_q          <= 80'd0;
      ks_byte_q     <= 8'd0;
      start_ready_q <= 1'b1;
      core_load_q   <= 1'b0;
      core_step_q   <= 1'b0;
      ks_valid_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      warm_cnt_q    <= warm_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bytes_left_q  <= bytes_left_d;
      key_q         <= key_d;
      iv_q          <= iv_d;
      ks_byte_q     <= ks_byte_d;
      start_ready_q <= (state_d == ST_IDLE);
      core_load_q   <= (state_d == ST_LOAD);
      core_step_q   <= (state_d == ST_WARM) || (state_d == ST_GEN);
      ks_valid_q    <= (state_d == ST_HOLD);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign bus.start_ready_o = start_ready_q;
  assign bus.core_load_o   = core_load_q;
  assign bus.core_key_o    = key_q;
  assign bus.core_iv_o     = iv_q;
  assign bus.core_step_o   = core_step_q;
  assign bus.done_o        = done_q;
`ifdef TRIV_XOR_EN
  assign bus.ks_data_o     = ks_valid_q ? (ks_byte_q ^ bus.din_i) : ks_byte_q;
  assign bus.ks_valid_o    = ks_valid_q & bus.din_valid_i;
  assign bus.din_ready_o   = ks_valid_q & bus.ks_ready_i;
`else
  assign bus.ks_data_o     = ks_byte_q;
  assign bus.ks_valid_o    = ks_valid_q;
`endif

endmodule

// File: tb/tb_trivium_ks_ctrl.sv
// Self-checking bench for trivium_ks_ctrl: a behavioural Trivium core sits on
// the core port, and expected bytes come from a Trivium keystream model.
module tb_trivium_ks_ctrl;

  localparam int WARMUP = 1152;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  int load_cnt = 0;
  int step_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int both_cnt = 0;

  logic [7:0]   exp_bytes [0:4095];
  logic [287:0] core_st = '0;
`ifdef TRIV_XOR_EN
  int xor_mode = 0;
`endif

  trivium_ks_ctrl_if #(.LEN_W(12)) bus ();

  trivium_ks_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Trivium state helpers: bit i-1 of the vector is textbook state bit s_i.
  function automatic logic [287:0] tri_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] st;
    st          = '0;
    st[79:0]    = k;
    st[172:93]  = v;
    st[287:285] = 3'b111;
    return st;
  endfunction

  function automatic logic tri_z(input logic [287:0] st);
    return st[65] ^ st[92] ^ st[161] ^ st[176] ^ st[242] ^ st[287];
  endfunction

  function automatic logic [287:0] tri_next(input logic [287:0] st);
    logic t1, t2, t3;
    t1 = st[65]  ^ st[92]  ^ (st[90]  & st[91])  ^ st[170];
    t2 = st[161] ^ st[176] ^ (st[174] & st[175]) ^ st[263];
    t3 = st[242] ^ st[287] ^ (st[285] & st[286]) ^ st[68];
    return {st[286:177], t2, st[175:93], t1, st[91:0], t3};
  endfunction

  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction

  // Behavioural core: loads / steps on the controller's registered commands.
  always @(posedge clk) begin
    if (bus.core_load_o) core_st <= tri_load(bus.core_key_o, bus.core_iv_o);
    else if (bus.core_step_o) core_st <= tri_next(core_st);
  end
  assign bus.core_ks_i = tri_z(core_st);

  // Cycle counters of the core and stream commands.
  always @(posedge clk) begin
    if (bus.core_load_o) load_cnt <= load_cnt + 1;
    if (bus.core_step_o) step_cnt <= step_cnt + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
    if (bus.ks_valid_o) valid_cnt <= valid_cnt + 1;
    if (bus.core_load_o && bus.core_step_o) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference keystream: WARMUP blank rounds, then bits packed LSB-first.
  task automatic build_model(input logic [79:0] k, input logic [79:0] v, input int n);
    logic [287:0] st;
    logic [7:0]   b;
    st = tri_load(k, v);
    for (int r = 0; r < WARMUP; r++) st = tri_next(st);
    for (int j = 0; j < n; j++) begin
      for (int i = 0; i < 8; i++) begin
        b[i] = tri_z(st);
        st   = tri_next(st);
      end
      exp_bytes[j] = b;
    end
  endtask

  task automatic run_job(input logic [79:0] k, input logic [79:0] v, input int n,
                         input int pct, input int stall, input string tag);
    int got, cyc, first_at, first_steps, l0, s0, d0, limit;
    bit stalled;
    logic [7:0] held, expv;
    build_model(k, v, n);
    l0 = load_cnt; s0 = step_cnt; d0 = done_cnt;
    got = 0; cyc = 0; first_at = -1; first_steps = -1; stalled = 1'b0;
    limit = 1300 + n * 60;
    bus.key_i = k; bus.iv_i = v; bus.len_i = 12'(n);
    bus.ks_ready_i = 1'b0; bus.start_i = 1'b1;
    check({tag, "_start_ready"}, bus.start_ready_o, 1'b1);
    @(negedge clk);
    bus.start_i = 1'b0;
    check({tag, "_load"}, bus.core_load_o, 1'b1);
    while (got < n && cyc < limit) begin
`ifdef TRIV_XOR_EN
      bus.din_valid_i = (xor_mode == 0 || got == 0) ? 1'b1 : 1'($urandom_range(1));
      bus.din_i = (xor_mode == 0 || got == 0) ? 8'h00 : (got == 1) ? 8'hA5 : 8'($urandom());
`endif
      bus.ks_ready_i = ($urandom_range(99) < pct);
      #1;
      if (first_at < 0 && bus.ks_valid_o) begin
        first_at = cyc;
        first_steps = step_cnt - s0;
      end
      if (stall > 0 && !stalled && bus.ks_valid_o) begin
        stalled = 1'b1;
        bus.ks_ready_i = 1'b0;
        held = bus.ks_data_o;
        for (int i = 0; i < stall; i++) begin
          @(negedge clk); cyc++; #1;
          check("stall_valid", bus.ks_valid_o, 1'b1);
          check("stall_data", bus.ks_data_o, held);
          check("stall_step", bus.core_step_o, 1'b0);
        end
        bus.ks_ready_i = 1'b1;
        #1;
      end
`ifdef TRIV_XOR_EN
      if (!bus.din_valid_i) check("xor_din_stall", bus.ks_valid_o, 1'b0);
      if (bus.ks_valid_o) check("xor_din_ready", bus.din_ready_o, bus.ks_ready_i);
      expv = exp_bytes[got] ^ bus.din_i;
`else
      expv = exp_bytes[got];
`endif
      if (bus.ks_valid_o && bus.ks_ready_i) begin
        check({tag, "_byte"}, bus.ks_data_o, expv);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_byte_count"}, got, n);
    check({tag, "_latency"}, first_at, WARMUP + 9);
    check({tag, "_warm_steps"}, first_steps, WARMUP + 8);
    check({tag, "_done_pulse"}, bus.done_o, 1'b1);
    bus.ks_ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_done_low"}, bus.done_o, 1'b0);
    check({tag, "_idle_ready"}, bus.start_ready_o, 1'b1);
    check({tag, "_loads"}, load_cnt - l0, 1);
    check({tag, "_steps"}, step_cnt - s0, WARMUP + 8 * n);
    check({tag, "_dones"}, done_cnt - d0, 1);
  endtask

  initial begin
    logic [79:0] k1;
    int l0, s0, d0, v0;
    bus.start_i = 1'b0; bus.key_i = 80'd0; bus.iv_i = 80'd0; bus.len_i = 12'd0;
    bus.abort_i = 1'b0; bus.ks_ready_i = 1'b0;
`ifdef TRIV_XOR_EN
    bus.din_i = 8'h00; bus.din_valid_i = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_start_ready", bus.start_ready_o, 1'b1);
    check("rst_core_load", bus.core_load_o, 1'b0);
    check("rst_core_step", bus.core_step_o, 1'b0);
    check("rst_ks_valid", bus.ks_valid_o, 1'b0);
    check("rst_done", bus.done_o, 1'b0);
    check("rst_ks_data", bus.ks_data_o, 8'h00);
    check("rst_core_key", bus.core_key_o, 80'd0);
    check("rst_core_iv", bus.core_iv_o, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.start_ready_o, 1'b1);

    // all-zero key/IV, four bytes, no backpressure
    run_job(80'd0, 80'd0, 4, 100, 0, "zero");

    // zero-length job never touches the core
    l0 = load_cnt; s0 = step_cnt; d0 = done_cnt;
    k1 = rand80();
    bus.key_i = k1; bus.len_i = 12'd0; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("len0_done", bus.done_o, 1'b1);
    check("len0_busy", bus.start_ready_o, 1'b0);
    check("len0_key_latched", bus.core_key_o, k1);
    @(negedge clk);
    check("len0_done_low", bus.done_o, 1'b0);
    check("len0_ready_back", bus.start_ready_o, 1'b1);
    repeat (4) @(negedge clk);
    check("len0_no_load", load_cnt - l0, 0);
    check("len0_no_step", step_cnt - s0, 0);
    check("len0_one_done", done_cnt - d0, 1);

    // downstream stalls 20 cycles in the first HOLD
    run_job(rand80(), rand80(), 2, 100, 20, "stall");

    // abort during warm-up, with an ignored start while busy
    d0 = done_cnt; v0 = valid_cnt;
    k1 = rand80();
    bus.key_i = k1; bus.iv_i = rand80(); bus.len_i = 12'd3; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (200) @(negedge clk);
    bus.key_i = rand80(); bus.len_i = 12'd0; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("busy_not_ready", bus.start_ready_o, 1'b0);
    check("busy_key_kept", bus.core_key_o, k1);
    repeat (299) @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_idle", bus.start_ready_o, 1'b1);
    check("abort_no_step", bus.core_step_o, 1'b0);
    check("abort_no_valid", bus.ks_valid_o, 1'b0);
    s0 = step_cnt;
    repeat (1300) @(negedge clk);
    check("abort_quiet_steps", step_cnt - s0, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_bytes", valid_cnt - v0, 0);
    run_job({80{1'b1}}, rand80(), 3, 100, 0, "after_abort");

    // start together with abort in IDLE is accepted; abort in LOAD cancels it
    bus.key_i = rand80(); bus.len_i = 12'd5; bus.start_i = 1'b1; bus.abort_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("abort_start_load", bus.core_load_o, 1'b1);
    check("abort_start_busy", bus.start_ready_o, 1'b0);
    @(negedge clk);
    bus.abort_i = 1'b0;
    check("abort_load_idle", bus.start_ready_o, 1'b1);
    check("abort_load_no_step", bus.core_step_o, 1'b0);

    // asynchronous reset in the middle of GEN
    bus.key_i = rand80(); bus.iv_i = rand80(); bus.len_i = 12'd4; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (1156) @(negedge clk);
    check("mid_gen_step", bus.core_step_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ready", bus.start_ready_o, 1'b1);
    check("async_rst_step", bus.core_step_o, 1'b0);
    check("async_rst_load", bus.core_load_o, 1'b0);
    check("async_rst_valid", bus.ks_valid_o, 1'b0);
    check("async_rst_data", bus.ks_data_o, 8'h00);
    check("async_rst_key", bus.core_key_o, 80'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job(rand80(), rand80(), 3, 70, 0, "after_reset");

    // random jobs with random backpressure
    for (int j = 0; j < 4; j++) begin
      run_job(rand80(), rand80(), int'($urandom_range(6, 1)), int'($urandom_range(100, 40)), 0, "rand");
    end

`ifdef TRIV_XOR_EN
    xor_mode = 1;
    run_job(rand80(), rand80(), 4, 80, 0, "xor");
    xor_mode = 0;
`endif

    // maximum length must not wrap the byte counter
    run_job(rand80(), rand80(), 4095, 100, 0, "max_len");

    check("load_step_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
